// File: rtl/alu_serial.sv
// alu_serial: multi-cycle ALU that processes SLICE bits per clock with a
// registered ripple carry between slices. Operands enter and results leave
// over valid/ready handshakes.
// Optional status flags are enabled with the ALU_FLAGS_EN macro. When it is
// undefined, carry, overflow and zero are tied low.

// One bit of the ALU datapath: a full adder for ADD/SUB/SLT, plus the
// bitwise logic ops.
module alu_serial_bit (
  input  logic [2:0] op,
  input  logic       a,
  input  logic       b,
  input  logic       ci,
  output logic       r,
  output logic       co
);
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_SLT = 3'd2, OP_XOR = 3'd3,
                         OP_AND = 3'd4, OP_NAND = 3'd5, OP_NOR = 3'd6, OP_OR = 3'd7;

  logic bx;

  // SUB and SLT add the inverted b; the +1 arrives through the carry chain.
  always_comb begin
    bx = b ^ ((op == OP_SUB) || (op == OP_SLT));
    r  = 1'b0;
    co = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_SLT: begin
        r  = a ^ bx ^ ci;
        co = (a & bx) | (a & ci) | (bx & ci);
      end
      OP_XOR:  r = a ^ b;
      OP_AND:  r = a & b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_OR:   r = a | b;
      default: r = 1'b0;
    endcase
  end
endmodule

module alu_serial #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);
  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_SLT = 3'd2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic            rdy_q, rdy_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [2:0]      op_q, op_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            cy_q, cy_d;

  // Slice datapath.
  int               idx;
  logic [SLICE-1:0] sa, sb, sr;
  logic [SLICE:0]   ch;
  logic             last, ovf_raw;
  logic [WIDTH-1:0] res_slice, res_fin;

  assign idx     = int'(cnt_q) * SLICE;
  assign sa      = a_q[idx +: SLICE];
  assign sb      = b_q[idx +: SLICE];
  assign ch[0]   = cy_q;
  assign last    = (cnt_q == CW'(N - 1));
  assign ovf_raw = ch[SLICE] ^ ch[SLICE-1];

  for (genvar i = 0; i < SLICE; i++) begin : g_bit
    alu_serial_bit u_bit (
      .op (op_q),
      .a  (sa[i]),
      .b  (sb[i]),
      .ci (ch[i]),
      .r  (sr[i]),
      .co (ch[i+1])
    );
  end

  // Merge the current slice into the result. On the last slice, SLT replaces
  // the whole result with the overflow-corrected sign of a-b.
  always_comb begin
    res_slice = res_q;
    res_slice[idx +: SLICE] = sr;
    res_fin = res_slice;
    if (op_q == OP_SLT) begin
      res_fin    = '0;
      res_fin[0] = sr[SLICE-1] ^ ovf_raw;
    end
  end

  // Control FSM next state: accept in IDLE, one slice per cycle in RUN, and
  // hold the result in DONE until it is consumed.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    cy_d    = cy_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && rdy_q) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          cnt_d   = '0;
          cy_d    = (op == OP_SUB) || (op == OP_SLT);
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        cy_d  = ch[SLICE];
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          res_d   = res_fin;
          state_d = S_DONE;
        end else begin
          res_d   = res_slice;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // in_ready is registered so it stays low while reset is high and does not
    // depend combinationally on any input.
    rdy_d = (state_d == S_IDLE);
  end

  // Control and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      rdy_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      res_q   <= res_d;
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = (state_q == S_DONE);
  assign result    = res_q;

`ifdef ALU_FLAGS_EN
  logic carry_q, carry_d, ovf_q, ovf_d, zero_q, zero_d;
  logic is_addsub;

  assign is_addsub = (op_q == OP_ADD) || (op_q == OP_SUB);

  // Flags are latched together with the final slice. Only ADD and SUB report
  // carry and overflow.
  always_comb begin
    carry_d = carry_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    if (state_q == S_RUN && last) begin
      carry_d = is_addsub & ch[SLICE];
      ovf_d   = is_addsub & ovf_raw;
      zero_d  = (res_fin == '0);
    end
  end

  // Flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign carry    = carry_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;
`else
  assign carry    = 1'b0;
  assign overflow = 1'b0;
  assign zero     = 1'b0;
`endif
endmodule

// File: tb/tb_alu_serial.sv
// Scoreboard bench for alu_serial (WIDTH=32, SLICE=8). The stimulus pushes
// the expected results. A monitor compares them on every cycle that
// out_valid is high and pops an entry when the result is consumed.
module tb_alu_serial;
  localparam int W = 32, S = 8;
`ifdef ALU_FLAGS_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif

  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic [2:0] op = '0;
  logic [W-1:0] a = '0, b = '0;
  logic in_ready, out_valid, carry, overflow, zero;
  logic [W-1:0] result;

  alu_serial #(.WIDTH(W), .SLICE(S)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] r;
    logic         c, v, z;
  } exp_t;

  exp_t q[$];
  int n_chk = 0, n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] r, input logic c, v, z);
    exp_t e;
    e.r = r; e.c = c & FE; e.v = v & FE; e.z = z & FE;
    return e;
  endfunction

  // Monitor: compare the presented result against the oldest expectation.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (q.size() == 0) chk("spurious_out_valid", 64'd1, 64'd0);
      else begin
        chk("result", result, q[0].r);
        chk("flags_cvz", {carry, overflow, zero}, {q[0].c, q[0].v, q[0].z});
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!in_ready) chk("in_ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_op(input logic [2:0] o, input logic [W-1:0] x, y, input exp_t e);
    int n = 0;
    wait_ready();
    in_valid = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    q.push_back(e);
    #1 in_valid = 1'b0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("latency", 64'(n), 64'd4);
  endtask

  initial begin
    int n;
    // State while reset is held.
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {carry, overflow, zero}, 0);
    chk("rst_in_ready", in_ready, 0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", in_ready, 1);

    // Backpressure, using the ADD carry-out case as the held result.
    out_ready = 1'b0;
    do_op(3'd0, 32'hFFFFFFFF, 32'h1, mk(32'h0, 1, 0, 1));
    for (int i = 0; i < 6; i++) begin
      a = $urandom; b = $urandom; op = 3'(i); in_valid = 1'b1;
      chk("bp_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    chk("bp_out_valid_held", out_valid, 1);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_in_ready_after", in_ready, 1);
    chk("bp_out_valid_drop", out_valid, 0);

    // Arithmetic and compare.
    do_op(3'd1, 32'h80000000, 32'h1, mk(32'h7FFFFFFF, 1, 1, 0));
    do_op(3'd2, 32'hFFFFFFFF, 32'h1, mk(32'h1, 0, 0, 0));
    do_op(3'd2, 32'h7FFFFFFF, 32'h80000000, mk(32'h0, 0, 0, 1));
    do_op(3'd0, 32'h7FFFFFFF, 32'h1, mk(32'h80000000, 0, 1, 0));
    do_op(3'd1, 32'h5, 32'h5, mk(32'h0, 1, 0, 1));

    // Logic ops.
    do_op(3'd3, 32'hF0F0F0F0, 32'hFF00FF00, mk(32'h0FF00FF0, 0, 0, 0));
    do_op(3'd4, 32'hF0F0F0F0, 32'hFF00FF00, mk(32'hF000F000, 0, 0, 0));
    do_op(3'd5, 32'hF0F0F0F0, 32'hFF00FF00, mk(32'h0FFF0FFF, 0, 0, 0));
    do_op(3'd6, 32'hF0F0F0F0, 32'hFF00FF00, mk(32'h000F000F, 0, 0, 0));
    do_op(3'd7, 32'hF0F0F0F0, 32'hFF00FF00, mk(32'hFFF0FFF0, 0, 0, 0));

    // Reset after two RUN cycles; the flags still hold the previous op's
    // values unless reset clears them.
    do_op(3'd0, 32'hFFFFFFFF, 32'h1, mk(32'h0, 1, 0, 1));
    wait_ready();
    in_valid = 1'b1; op = 3'd0; a = 32'h01010101; b = 32'h01010101;
    @(posedge clk);
    q.push_back(mk(32'h02020202, 0, 0, 0));
    #1 in_valid = 1'b0;
    @(posedge clk); @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midrun_out_valid", out_valid, 0);
    chk("midrun_result", result, 0);
    chk("midrun_flags", {carry, overflow, zero}, 0);
    chk("midrun_in_ready", in_ready, 0);
    void'(q.pop_front());
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    do_op(3'd0, 32'd3, 32'd4, mk(32'd7, 0, 0, 0));

    // Drain the scoreboard.
    n = 0;
    while (q.size() != 0 && n < 50) begin @(posedge clk); #1; n++; end
    chk("drain", 64'(q.size()), 64'd0);
    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
